// File: rtl/cop_spi_master_pkg.sv
// Shared definitions for the coprocessor-side SPI master: byte width, device
// select codes and the coprocessor opcodes used by software and the bench.
package cop_spi_master_pkg;

   localparam int unsigned BYTE_WIDTH       = 8;
   localparam int unsigned DEV_SELECT_WIDTH = 3;

   typedef logic [DEV_SELECT_WIDTH-1:0] dev_sel_t;

   localparam dev_sel_t DEV_SELECT_NONE   = 3'd0;
   localparam dev_sel_t DEV_SELECT_LOGIC  = 3'd1;
   localparam dev_sel_t DEV_SELECT_SDCARD = 3'd2;
   localparam dev_sel_t DEV_SELECT_USB    = 3'd3;
   localparam dev_sel_t DEV_SELECT_FPGA   = 3'd4;
   localparam dev_sel_t DEV_SELECT_FLASH  = 3'd5;

   localparam logic [BYTE_WIDTH-1:0] COP_OP_NOP          = 8'h00;
   localparam logic [BYTE_WIDTH-1:0] COP_OP_WRITE_STATUS = 8'h01;
   localparam logic [BYTE_WIDTH-1:0] COP_OP_WRITE_DATA   = 8'h02;
   localparam logic [BYTE_WIDTH-1:0] COP_OP_READ_DATA    = 8'h03;
   localparam logic [BYTE_WIDTH-1:0] COP_OP_READ_STATUS  = 8'h05;
   localparam logic [BYTE_WIDTH-1:0] COP_OP_RESET        = 8'hFF;

endpackage

// File: rtl/spi_phase_timer.sv
// Counts CLK_DIV clk cycles while run_i is high and strobes phase_end_o on the
// last cycle of each phase; the count restarts whenever run_i drops.
module spi_phase_timer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic nreset,
   input  logic run_i,
   output logic phase_end_o
);

   localparam logic [7:0] LAST_COUNT = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   assign phase_end_o = run_i && (cnt_q == LAST_COUNT);

   always_comb begin
      cnt_d = cnt_q;
      if (!run_i || phase_end_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cop_spi_master.sv
// SPI mode 0, MSB-first master framing a valid/ready byte stream into device
// transactions. Optional NEXT-state idle abort: COP_SPI_IDLE_TIMEOUT_EN.
module cop_spi_master
   import cop_spi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV          = 4,
   parameter int unsigned DEV_SELECT_WIDTH = cop_spi_master_pkg::DEV_SELECT_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
   input  logic                        clk,
   input  logic                        nreset,
   input  logic [DEV_SELECT_WIDTH-1:0] dev_sel,
   input  logic                        tx_valid,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_last,
   output logic                        tx_ready,
   output logic                        rx_valid,
   output logic [7:0]                  rx_data,
   output logic                        busy,
   output logic                        abort,
   output logic [DEV_SELECT_WIDTH-1:0] cop_select,
   output logic                        cop_sck,
   output logic                        cop_mosi,
   input  logic                        cop_miso
);

   // Handshake: a byte moves when tx_valid && tx_ready at a rising clk edge;
   // tx_ready is registered and is high only in IDLE and NEXT.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_NEXT,
      ST_HOLD,
      ST_GAP
   } state_e;

   localparam logic [DEV_SELECT_WIDTH-1:0] SEL_NONE = DEV_SELECT_WIDTH'(DEV_SELECT_NONE);

   state_e                      state_q, state_d;
   logic [DEV_SELECT_WIDTH-1:0] sel_q, sel_d;
   logic                        sck_q, sck_d;
   logic                        mosi_q, mosi_d;
   logic [7:0]                  tx_shift_q, tx_shift_d;
   logic [7:0]                  rx_shift_q, rx_shift_d;
   logic [7:0]                  rx_data_q, rx_data_d;
   logic                        rx_valid_q, rx_valid_d;
   logic [2:0]                  bit_cnt_q, bit_cnt_d;
   logic                        last_q, last_d;
   logic                        tx_ready_q, tx_ready_d;

   logic accept;
   logic timer_run;
   logic phase_end;
   logic timeout_hit;

   assign accept    = tx_valid && tx_ready_q;
   assign timer_run = (state_q == ST_SHIFT) || (state_q == ST_HOLD) || (state_q == ST_GAP);

   spi_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_timer (
      .clk         (clk),
      .nreset      (nreset),
      .run_i       (timer_run),
      .phase_end_o (phase_end)
   );

`ifdef COP_SPI_IDLE_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
   logic            abort_q;

   assign timeout_hit = (state_q == ST_NEXT) && !accept &&
                        (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      idle_cnt_d = '0;
      if ((state_q == ST_NEXT) && !accept) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         idle_cnt_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         abort_q    <= timeout_hit;
      end
   end

   assign abort = abort_q;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
   assign abort              = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      bit_cnt_d  = bit_cnt_q;
      last_d     = last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               sel_d = dev_sel;
            end
         end
         ST_SHIFT: begin
            if (phase_end) begin
               if (!sck_q) begin
                  // Rising SCK: capture MISO; first bit ends up as the MSB.
                  sck_d      = 1'b1;
                  rx_shift_d = {rx_shift_q[6:0], cop_miso};
               end else begin
                  sck_d = 1'b0;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = rx_shift_q;
                     rx_valid_d = 1'b1;
                     state_d    = last_q ? ST_HOLD : ST_NEXT;
                  end else begin
                     bit_cnt_d  = bit_cnt_q + 3'd1;
                     mosi_d     = tx_shift_q[6];
                     tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  end
               end
            end
         end
         ST_NEXT: begin
            if (timeout_hit) begin
               sel_d   = SEL_NONE;
               state_d = ST_GAP;
            end
         end
         ST_HOLD: begin
            if (phase_end) begin
               sel_d   = SEL_NONE;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (phase_end) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // accept implies IDLE or NEXT, so this only overrides those two states.
      if (accept) begin
         state_d    = ST_SHIFT;
         sck_d      = 1'b0;
         mosi_d     = tx_data[7];
         tx_shift_d = tx_data;
         bit_cnt_d  = 3'd0;
         last_d     = tx_last;
      end

      tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_NEXT);
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= ST_IDLE;
         sel_q      <= SEL_NONE;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         bit_cnt_q  <= '0;
         last_q     <= 1'b0;
         tx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         bit_cnt_q  <= bit_cnt_d;
         last_q     <= last_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   assign tx_ready   = tx_ready_q;
   assign rx_valid   = rx_valid_q;
   assign rx_data    = rx_data_q;
   assign busy       = (state_q != ST_IDLE);
   assign cop_select = sel_q;
   assign cop_sck    = sck_q;
   assign cop_mosi   = mosi_q;

endmodule

// File: tb/tb_cop_spi_master.sv
// Scoreboard bench for cop_spi_master with CLK_DIV=2 and MISO looped back as
// the inverse of MOSI, so every received byte is the complement of the sent one.
module tb_cop_spi_master;
   import cop_spi_master_pkg::*;

   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned BYTE_T  = 16 * CLK_DIV * 10 + 5;

   logic       clk;
   logic       nreset;
   logic [2:0] dev_sel;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       busy;
   logic       abort;
   logic [2:0] cop_select;
   logic       cop_sck;
   logic       cop_mosi;
   logic       cop_miso;

   assign cop_miso = ~cop_mosi;

   cop_spi_master #(
     .CLK_DIV          (CLK_DIV),
     .DEV_SELECT_WIDTH (3),
     .TIMEOUT_CYCLES   (16)
   ) dut (
     .clk        (clk),
     .nreset     (nreset),
     .dev_sel    (dev_sel),
     .tx_valid   (tx_valid),
     .tx_data    (tx_data),
     .tx_last    (tx_last),
     .tx_ready   (tx_ready),
     .rx_valid   (rx_valid),
     .rx_data    (rx_data),
     .busy       (busy),
     .abort      (abort),
     .cop_select (cop_select),
     .cop_sck    (cop_sck),
     .cop_mosi   (cop_mosi),
     .cop_miso   (cop_miso)
   );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_tx_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         rv_n     = 0;
  time        rv_t     = 0;
  int         bit_n    = 0;
  int         rise_total = 0;
  int         abort_n  = 0;
  int         sel_drop_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [7:0] mosi_cap;
    logic       sck_prev;
    logic [2:0] sel_prev;
    logic [7:0] exp_rx;
    logic [7:0] exp_tx;
    mosi_cap = '0;
    sck_prev = 1'b0;
    sel_prev = DEV_SELECT_NONE;
    forever begin
      @(negedge clk);
      if (sel_prev != DEV_SELECT_NONE && cop_select == DEV_SELECT_NONE) sel_drop_n++;
      sel_prev = cop_select;
      if (!nreset) begin
        mosi_cap = '0;
        sck_prev = 1'b0;
        bit_n    = 0;
      end else begin
        if (cop_sck && !sck_prev) begin
          mosi_cap = {mosi_cap[6:0], cop_mosi};
          bit_n++;
          rise_total++;
        end
        sck_prev = cop_sck;
        if (abort) abort_n++;
        if (rx_valid) begin
          rv_n++;
          rv_t = $time;
          check("rx_expected_pending", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp_rx = exp_q.pop_front();
            exp_tx = exp_tx_q.pop_front();
            check("rx_data", rx_data, exp_rx);
            check("mosi_byte", mosi_cap, exp_tx);
            check("sck_pulses_per_byte", bit_n, 8);
            check("sck_low_at_rx_valid", cop_sck, 0);
          end
          bit_n = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [2:0] sel, input logic [7:0] data, input logic last,
                           input bit hold, input bit expect_rx,
                           output time acc_t, output int waited);
    waited   = 0;
    dev_sel  = sel;
    tx_data  = data;
    tx_last  = last;
    tx_valid = 1'b1;
    if (expect_rx) begin
      exp_q.push_back(~data);
      exp_tx_q.push_back(data);
    end
    while (!tx_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(waited < 200), 1);
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int w = 0;
    while (rv_n < target && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("rx_wait", 32'(rv_n >= target), 1);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(busy == 1'b0 && tx_ready == 1'b1) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", 32'(w < 1000), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    time        acc_t;
    time        prev_acc;
    time        t_ab;
    int         waited;
    int         cnt;
    int         drops0;
    int         rv0;
    int         rise0;
    logic [7:0] frame [5];

    frame    = '{COP_OP_WRITE_STATUS, 8'd31, 8'd85, 8'd131, 8'd200};
    nreset   = 1'b0;
    dev_sel  = DEV_SELECT_NONE;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_select", cop_select, DEV_SELECT_NONE);
    check("rst_sck", cop_sck, 0);
    check("rst_mosi", cop_mosi, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_abort", abort, 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check("idle_tx_ready", tx_ready, 1);

    // Single byte 0x91 to LOGIC, then 0xA5 offered during the gap
    send_byte(DEV_SELECT_LOGIC, 8'h91, 1'b1, 1'b0, 1'b1, acc_t, waited);
    check("t1_mosi_bit7", cop_mosi, 1);
    cnt = 0;
    while (cop_select == DEV_SELECT_LOGIC && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("t1_select_cycles", cnt, 34);
    check("t1_rx_latency", 32'(rv_t - acc_t), BYTE_T);
    check("t1_gap_tx_ready", tx_ready, 0);
    check("t1_gap_busy", busy, 1);
    send_byte(DEV_SELECT_SDCARD, 8'hA5, 1'b1, 1'b0, 1'b1, acc_t, waited);
    check("t3_backpressure_wait", waited, 2);
    check("t3_select", cop_select, DEV_SELECT_SDCARD);
    wait_rx(2);
    wait_idle();

    // Multi-byte frame, tx_valid held, dev_sel changed after byte 0
    drops0 = sel_drop_n;
    rv0    = rv_n;
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      send_byte((i == 0) ? DEV_SELECT_LOGIC : DEV_SELECT_FLASH, frame[i], 1'(i == 4),
                1'(i != 4), 1'b1, acc_t, waited);
      check("t2_frame_select", cop_select, DEV_SELECT_LOGIC);
      if (i > 0) begin
        check("t2_accept_on_rx_valid", 32'(acc_t - rv_t), 5);
        check("t2_byte_time", 32'(rv_t - prev_acc), BYTE_T);
      end
      prev_acc = acc_t;
    end
    wait_rx(rv0 + 5);
    check("t2_last_byte_time", 32'(rv_t - prev_acc), BYTE_T);
    check("t2_rx_count", rv_n - rv0, 5);
    wait_idle();
    check("t2_select_drops", sel_drop_n - drops0, 1);

    // Reset in the middle of a byte
    rv0 = rv_n;
    send_byte(DEV_SELECT_USB, 8'hFF, 1'b1, 1'b0, 1'b0, acc_t, waited);
    cnt = 0;
    while (bit_n < 3 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("t4_reached_third_rise", 32'(bit_n >= 3), 1);
    nreset = 1'b0;
    @(negedge clk);
    check("t4_rst_select", cop_select, DEV_SELECT_NONE);
    check("t4_rst_sck", cop_sck, 0);
    check("t4_rst_tx_ready", tx_ready, 0);
    check("t4_rst_busy", busy, 0);
    check("t4_rst_rx_valid", rx_valid, 0);
    nreset = 1'b1;
    rise0  = rise_total;
    @(negedge clk);
    check("t4_idle_tx_ready", tx_ready, 1);
    check("t4_idle_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("t4_no_sck_after_reset", rise_total - rise0, 0);
    check("t4_no_partial_rx", rv_n - rv0, 0);

    // Stall in NEXT
    rv0 = rv_n;
    send_byte(DEV_SELECT_FPGA, 8'h42, 1'b0, 1'b0, 1'b1, acc_t, waited);
    wait_rx(rv0 + 1);
`ifdef COP_SPI_IDLE_TIMEOUT_EN
    cnt = 0;
    while (!abort && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    t_ab = $time;
    check("t5_abort_seen", abort, 1);
    check("t5_abort_delay", 32'(t_ab - rv_t), 160);
    check("t5_abort_select", cop_select, DEV_SELECT_NONE);
    check("t5_abort_busy", busy, 1);
    @(negedge clk);
    check("t5_abort_one_cycle", abort, 0);
    check("t5_gap_busy", busy, 1);
    @(negedge clk);
    check("t5_busy_clear", busy, 0);
`else
    t_ab = 0;
    repeat (200) @(negedge clk);
    check("t5_select_held", cop_select, DEV_SELECT_FPGA);
    check("t5_no_abort", abort_n, 0);
    check("t5_busy_held", busy, 1);
    check("t5_tx_ready_next", tx_ready, 1);
    send_byte(DEV_SELECT_NONE, 8'h18, 1'b1, 1'b0, 1'b1, acc_t, waited);
    check("t5_select_after_resume", cop_select, DEV_SELECT_FPGA);
    wait_rx(rv0 + 2);
    check("t5_resume_byte_time", 32'(rv_t - acc_t), BYTE_T);
`endif
    wait_idle();
    check("t5_t_ab_unused", 32'(t_ab >= 0), 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
